// File: rtl/bus_rr_scheduler.sv
// rtl/bus_rr_scheduler.sv - round-robin pop/decode/push scheduler for the shared packet bus
// Define BUS_RR_BCAST_SELF_EN to include the source device in broadcast deliveries.
module bus_rr_scheduler #(
    parameter int         drvrs     = 4,
    parameter int         pckg_sz   = 16,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [drvrs-1:0]           pndng,
    input  logic [pckg_sz*drvrs-1:0]   D_pop,
    input  logic [drvrs-1:0]           dst_full,
    output logic [drvrs-1:0]           pop,
    output logic [drvrs-1:0]           push,
    output logic [pckg_sz-1:0]         D_push,
    output logic [$clog2(drvrs)-1:0]   grant_id,
    output logic                       busy,
    output logic                       drop_err
);

    localparam int GW = $clog2(drvrs);
    localparam logic [drvrs-1:0] ONE  = {{(drvrs-1){1'b0}}, 1'b1};
    localparam logic [GW-1:0]    LAST = GW'(drvrs - 1);

    typedef enum logic [1:0] {IDLE, POP, DECODE, PUSH} state_t;

    state_t              state, state_n;
    logic [GW-1:0]       last_grant, last_grant_n;
    logic [GW-1:0]       grant_n;
    logic [pckg_sz-1:0]  pkt, pkt_n;
    logic [pckg_sz-1:0]  d_push_n;
    logic [drvrs-1:0]    dst_mask, dst_mask_n;
    logic [drvrs-1:0]    pop_n, push_n;
    logic                busy_n, drop_n;

    logic [GW-1:0]       arb_idx;
    int                  arb_best, arb_dist;
    logic [pckg_sz-1:0]  src_data;
    logic [7:0]          dst;

    // Winner is the pending device with the smallest rotational distance past last_grant.
    always_comb begin
        arb_idx  = LAST;
        arb_best = drvrs;
        arb_dist = 0;
        for (int i = 0; i < drvrs; i++) begin
            arb_dist = (i - int'(last_grant) - 1 + 2 * drvrs) % drvrs;
            if (pndng[i] && arb_dist < arb_best) begin
                arb_best = arb_dist;
                arb_idx  = GW'(i);
            end
        end
    end

    always_comb begin
        src_data = '0;
        for (int i = 0; i < drvrs; i++) begin
            if (GW'(i) == grant_id) begin
                src_data = D_pop[i*pckg_sz +: pckg_sz];
            end
        end
    end

    assign dst = pkt[pckg_sz-1 -: 8];

    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        grant_n      = grant_id;
        pkt_n        = pkt;
        d_push_n     = D_push;
        dst_mask_n   = dst_mask;
        pop_n        = '0;
        push_n       = '0;
        drop_n       = 1'b0;
        case (state)
            IDLE: begin
                if (|pndng) begin
                    grant_n = arb_idx;
                    pop_n   = ONE << arb_idx;
                    state_n = POP;
                end
            end
            POP: begin
                pkt_n        = src_data;
                last_grant_n = grant_id;
                state_n      = DECODE;
            end
            DECODE: begin
                if (dst == broadcast) begin
`ifdef BUS_RR_BCAST_SELF_EN
                    dst_mask_n = '1;
`else
                    dst_mask_n = ~(ONE << last_grant);
`endif
                    state_n = PUSH;
                end else if (int'(dst) < drvrs) begin
                    dst_mask_n = ONE << dst;
                    state_n    = PUSH;
                end else begin
                    dst_mask_n = '0;
                    drop_n     = 1'b1;
                    state_n    = IDLE;
                end
            end
            PUSH: begin
                d_push_n = pkt;
                // Broadcast is all-or-nothing: any full target stalls the whole delivery.
                if ((dst_mask & dst_full) == '0) begin
                    push_n  = dst_mask;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= LAST;
            grant_id   <= LAST;
            pkt        <= '0;
            dst_mask   <= '0;
            pop        <= '0;
            push       <= '0;
            D_push     <= '0;
            busy       <= 1'b0;
            drop_err   <= 1'b0;
        end else begin
            state      <= state_n;
            last_grant <= last_grant_n;
            grant_id   <= grant_n;
            pkt        <= pkt_n;
            dst_mask   <= dst_mask_n;
            pop        <= pop_n;
            push       <= push_n;
            D_push     <= d_push_n;
            busy       <= busy_n;
            drop_err   <= drop_n;
        end
    end

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// tb/tb_bus_rr_scheduler.sv - self-checking bench for bus_rr_scheduler
module tb_bus_rr_scheduler;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   pndng, dst_full, pop, push;
    logic [W*N-1:0] D_pop;
    logic [W-1:0]   D_push;
    logic [1:0]     grant_id;
    logic           busy, drop_err;

    int total = 0;
    int bad   = 0;

    bus_rr_scheduler #(.drvrs(N), .pckg_sz(W), .broadcast(8'hFF)) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .dst_full(dst_full),
        .pop(pop), .push(push), .D_push(D_push), .grant_id(grant_id),
        .busy(busy), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] model_mask(input logic [W-1:0] p, input int src);
        logic [7:0]   d;
        logic [N-1:0] m;
        d = p[W-1 -: 8];
        if (d == 8'hFF) begin
`ifdef BUS_RR_BCAST_SELF_EN
            m = '1;
`else
            m = '1;
            m[src] = 1'b0;
`endif
        end else if (int'(d) < N) begin
            m = '0;
            m[d] = 1'b1;
        end else begin
            m = '0;
        end
        return m;
    endfunction

    function automatic int model_rr(input int last, input logic [N-1:0] req);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] rand_pkt();
        int r;
        logic [7:0] d;
        r = $urandom_range(0, 9);
        if (r < 7)      d = 8'($urandom_range(0, N - 1));
        else if (r < 9) d = 8'hFF;
        else            d = 8'($urandom_range(N, 254));
        return {d, 8'($urandom)};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; pndng = '0; dst_full = '0; D_pop = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_one(input int src, input logic [W-1:0] pkt, input int cycles,
                            output logic [N-1:0] pop_seen, output logic [N-1:0] push_seen,
                            output int push_cnt, output int drop_cnt, output logic [W-1:0] data_seen);
        logic popped;
        popped = 1'b0; pop_seen = '0; push_seen = '0; push_cnt = 0; drop_cnt = 0; data_seen = '0;
        D_pop = '0;
        D_pop[src*W +: W] = pkt;
        pndng = '0;
        pndng[src] = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (popped) pndng = '0;
            if (pop != '0) begin pop_seen |= pop; popped = 1'b1; end
            if (push != '0) begin push_seen = push; push_cnt++; data_seen = D_push; end
            if (drop_err) drop_cnt++;
        end
        pndng = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; pndng = '0; dst_full = '0; D_pop = '0;
        #20 reset = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            total++;
            if ({pop, push, busy, grant_id, drop_err, D_push} !== {4'b0, 4'b0, 1'b0, 2'd3, 1'b0, 16'h0}) begin
                bad++;
                $display("FAIL reset_idle cycle=%0d pop=%b push=%b busy=%b grant=%0d drop=%b dpush=%h, want 0 0 0 3 0 0",
                         c, pop, push, busy, grant_id, drop_err, D_push);
            end
        end
    endtask

    task automatic test_single();
        D_pop = '0;
        D_pop[1*W +: W] = 16'h02AB;
        pndng = 4'b0010;
        @(negedge clk);
        total++;
        if ({pop, grant_id, busy} !== {4'b0010, 2'd1, 1'b1}) begin
            bad++; $display("FAIL single_pop pop=%b grant=%0d busy=%b, want 0010 1 1", pop, grant_id, busy);
        end
        @(negedge clk);
        pndng = '0;
        total++;
        if ({pop, push, busy} !== {4'b0, 4'b0, 1'b1}) begin
            bad++; $display("FAIL single_c2 pop=%b push=%b busy=%b, want 0000 0000 1", pop, push, busy);
        end
        @(negedge clk);
        total++;
        if ({push, busy} !== {4'b0, 1'b1}) begin
            bad++; $display("FAIL single_c3 push=%b busy=%b, want 0000 1", push, busy);
        end
        @(negedge clk);
        total++;
        if ({push, D_push, busy} !== {4'b0100, 16'h02AB, 1'b0}) begin
            bad++; $display("FAIL single_push push=%b dpush=%h busy=%b, want 0100 02ab 0", push, D_push, busy);
        end
        @(negedge clk);
        total++;
        if ({push, D_push} !== {4'b0000, 16'h02AB}) begin
            bad++; $display("FAIL single_hold push=%b dpush=%h, want 0000 02ab", push, D_push);
        end
    endtask

    task automatic test_rr_order();
        int npop, npush;
        do_reset();
        for (int i = 0; i < N; i++) D_pop[i*W +: W] = {8'h00, 8'(8'hA0 + i)};
        pndng = 4'b1111;
        npop = 0; npush = 0;
        for (int c = 0; c < 40 && npush < 5; c++) begin
            @(negedge clk);
            if (pop != '0) begin
                total++;
                if (pop !== (4'b0001 << (npop % N)) || int'(grant_id) != npop % N) begin
                    bad++; $display("FAIL rr_grant n=%0d pop=%b grant=%0d, want grant %0d", npop, pop, grant_id, npop % N);
                end
                npop++;
            end
            if (push != '0) begin
                total++;
                if ({push, D_push} !== {4'b0001, 8'h00, 8'(8'hA0 + (npush % N))}) begin
                    bad++; $display("FAIL rr_push n=%0d push=%b dpush=%h, want 0001 00%h", npush, push, D_push, 8'(8'hA0 + (npush % N)));
                end
                npush++;
            end
        end
        pndng = '0;
        total++;
        if (npush != 5) begin
            bad++; $display("FAIL rr_count pushes=%0d, want 5", npush);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_broadcast();
        logic [N-1:0] ps, pu;
        int pc, dc;
        logic [W-1:0] dv;
        send_one(2, 16'hFF55, 10, ps, pu, pc, dc, dv);
        total++;
`ifdef BUS_RR_BCAST_SELF_EN
        if ({ps, pu, pc, dc, dv} !== {4'b0100, 4'b1111, 32'd1, 32'd0, 16'hFF55}) begin
`else
        if ({ps, pu, pc, dc, dv} !== {4'b0100, 4'b1011, 32'd1, 32'd0, 16'hFF55}) begin
`endif
            bad++; $display("FAIL bcast pop=%b push=%b npush=%0d ndrop=%0d data=%h", ps, pu, pc, dc, dv);
        end
    endtask

    task automatic test_drop();
        logic [N-1:0] ps, pu;
        int pc, dc;
        logic [W-1:0] dv;
        send_one(0, 16'h0711, 10, ps, pu, pc, dc, dv);
        total++;
        if ({ps, pc, dc, busy} !== {4'b0001, 32'd0, 32'd1, 1'b0}) begin
            bad++; $display("FAIL drop pop=%b npush=%0d ndrop=%0d busy=%b, want 0001 0 1 0", ps, pc, dc, busy);
        end
    endtask

    task automatic test_stall();
        int c;
        dst_full = 4'b1000;
        D_pop = '0;
        D_pop[1*W +: W] = 16'h03C3;
        pndng = 4'b0010;
        c = 0;
        do begin @(negedge clk); c++; end while (pop == '0 && c < 10);
        total++;
        if (pop !== 4'b0010) begin bad++; $display("FAIL stall_pop pop=%b, want 0010", pop); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            pndng = '0;
            total++;
            if (push !== 4'b0) begin bad++; $display("FAIL stall_hold k=%0d push=%b, want 0000", k, push); end
        end
        total++;
        if (D_push !== 16'h03C3) begin bad++; $display("FAIL stall_dpush dpush=%h, want 03c3", D_push); end
        dst_full = '0;
        @(negedge clk);
        total++;
        if ({push, D_push} !== {4'b1000, 16'h03C3}) begin
            bad++; $display("FAIL stall_release push=%b dpush=%h, want 1000 03c3", push, D_push);
        end
        @(negedge clk);
        total++;
        if (push !== 4'b0) begin bad++; $display("FAIL stall_once push=%b, want 0000", push); end
    endtask

    task automatic test_reset_stall();
        int c, stray;
        logic [N-1:0] first;
        dst_full = 4'b1000;
        D_pop = '0;
        D_pop[1*W +: W] = 16'h03C3;
        pndng = 4'b0010;
        c = 0;
        do begin @(negedge clk); c++; end while (pop == '0 && c < 10);
        repeat (4) begin @(negedge clk); pndng = '0; end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({pop, push, busy, grant_id} !== {4'b0, 4'b0, 1'b0, 2'd3}) begin
            bad++; $display("FAIL rst_async pop=%b push=%b busy=%b grant=%0d, want 0 0 0 3", pop, push, busy, grant_id);
        end
        @(negedge clk);
        reset = 1'b0;
        dst_full = '0;
        for (int i = 0; i < N; i++) D_pop[i*W +: W] = {8'h00, 8'(8'hE0 + i)};
        pndng = 4'b1111;
        first = '0; stray = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (first != '0) pndng = '0;
            if (pop != '0 && first == '0) first = pop;
            if (push[3] || D_push == 16'h03C3) stray++;
        end
        total++;
        if (first !== 4'b0001 || stray != 0) begin
            bad++; $display("FAIL rst_resume first_pop=%b stray=%0d, want 0001 0", first, stray);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] fifo [N][$];
        logic [N-1:0] sb_mask [$];
        logic [W-1:0] sb_data [$];
        logic [N-1:0] prev_req, prev_full;
        int last_m, pend, g, s;
        do_reset();
        last_m = N - 1; pend = -1; prev_req = '0; prev_full = '0;
        for (int cyc = 0; cyc < 1600; cyc++) begin
            @(negedge clk);
            if (pend >= 0) begin void'(fifo[pend].pop_front()); pend = -1; end
            if (pop != '0) begin
                g = model_rr(last_m, prev_req);
                total++;
                if (g < 0 || pop !== (4'b0001 << g) || sb_mask.size() != 0) begin
                    bad++; $display("FAIL rand_grant cyc=%0d pop=%b want_src=%0d inflight=%0d", cyc, pop, g, sb_mask.size());
                end
                if (g >= 0 && fifo[g].size() != 0) begin
                    sb_mask.push_back(model_mask(fifo[g][0], g));
                    sb_data.push_back(fifo[g][0]);
                    last_m = g; pend = g;
                end
            end
            if (push != '0) begin
                total++;
                if (sb_mask.size() == 0) begin
                    bad++; $display("FAIL rand_push_unexpected cyc=%0d push=%b", cyc, push);
                end else begin
                    if (push !== sb_mask[0] || D_push !== sb_data[0]) begin
                        bad++; $display("FAIL rand_push cyc=%0d push=%b data=%h, want %b %h", cyc, push, D_push, sb_mask[0], sb_data[0]);
                    end
                    void'(sb_mask.pop_front()); void'(sb_data.pop_front());
                end
                total++;
                if ((push & prev_full) != '0) begin
                    bad++; $display("FAIL rand_push_full cyc=%0d push=%b full=%b, want no overlap", cyc, push, prev_full);
                end
            end
            if (drop_err) begin
                total++;
                if (sb_mask.size() == 0 || sb_mask[0] != '0) begin
                    bad++; $display("FAIL rand_drop cyc=%0d unexpected drop_err", cyc);
                end else begin
                    void'(sb_mask.pop_front()); void'(sb_data.pop_front());
                end
            end
            if (cyc < 1200 && $urandom_range(0, 2) == 0) begin
                s = $urandom_range(0, N - 1);
                if (fifo[s].size() < 4) fifo[s].push_back(rand_pkt());
            end
            for (int i = 0; i < N; i++) begin
                dst_full[i] = (cyc < 1200) && ($urandom_range(0, 3) == 0);
                pndng[i] = (fifo[i].size() != 0);
                D_pop[i*W +: W] = (fifo[i].size() != 0) ? fifo[i][0] : '0;
            end
            prev_full = dst_full;
            prev_req = pndng;
        end
        total++;
        if (fifo[0].size() + fifo[1].size() + fifo[2].size() + fifo[3].size() + sb_mask.size() != 0) begin
            bad++; $display("FAIL rand_drain left=%0d inflight=%0d, want 0 0",
                            fifo[0].size() + fifo[1].size() + fifo[2].size() + fifo[3].size(), sb_mask.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr_order();
        test_broadcast();
        test_drop();
        test_stall();
        test_reset_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
